// File: rtl/n64_timer_pkg.sv
// Shared channel state encoding, mode constants and N64 bit-cell timing loads
// for the n64_timer_bank controller-interface timers.
package n64_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Cell counts at a 50 MHz board clock; all fit the default 8-bit counter.
    localparam int unsigned CLK_MHZ  = 50;
    localparam int unsigned CELL_1US = CLK_MHZ;
    localparam int unsigned CELL_3US = 3 * CLK_MHZ;

endpackage

// File: rtl/n64_timer_channel.sv
// One down-counting interval timer: latched load/mode, IDLE/RUN state,
// registered one-cycle expire pulse. Decrements only when tick is high.
module n64_timer_channel
    import n64_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             reload_mode,
    input  logic [WIDTH-1:0] load_val,
    output logic             empty,
    output logic             expire,
    output logic [WIDTH-1:0] count
);

    chan_state_t      state, state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_q, load_next;
    logic             mode_q, mode_next;
    logic             expire_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            expire <= 1'b0;
            load_q <= '0;
            mode_q <= MODE_ONESHOT;
        end else begin
            state  <= state_next;
            count  <= count_next;
            expire <= expire_next;
            load_q <= load_next;
            mode_q <= mode_next;
        end
    end

    // Priority: start > stop > hold > decrement; a zero load expires at once.
    always_comb begin
        state_next  = state;
        count_next  = count;
        expire_next = 1'b0;
        load_next   = load_q;
        mode_next   = mode_q;
        if (start) begin
            load_next = load_val;
            mode_next = reload_mode;
            if (load_val == '0) begin
                state_next  = IDLE;
                count_next  = '0;
                expire_next = 1'b1;
            end else begin
                state_next = RUN;
                count_next = load_val;
            end
        end else if (stop) begin
            state_next = IDLE;
            count_next = '0;
        end else if (!hold && tick && state == RUN) begin
            if (count > WIDTH'(1)) begin
                count_next = count - 1'b1;
            end else begin
                expire_next = 1'b1;
                if (mode_q == MODE_RELOAD) begin
                    count_next = load_q;
                end else begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
        end
    end

    assign empty = (state == IDLE);

endmodule

// File: rtl/n64_timer_bank.sv
// Bank of CHANNELS independent N64 interval timers sharing one tick.
// Define TIMER_PRESCALE_EN to divide the tick by PRESCALE.
module n64_timer_bank
    import n64_timer_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       hold,
    input  logic [CHANNELS-1:0]       reload_mode,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS-1:0]       empty,
    output logic [CHANNELS-1:0]       expire,
    output logic [CHANNELS*WIDTH-1:0] count
);

    logic tick;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_cnt;

    // Free-running divider; only reset clears it, channel starts do not.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == PW'(PRESCALE - 1));
`else
    // Undivided build: every clock is a tick and PRESCALE has no effect.
    assign tick = (PRESCALE >= 1) | 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        n64_timer_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .start      (start[i]),
            .stop       (stop[i]),
            .hold       (hold[i]),
            .reload_mode(reload_mode[i]),
            .load_val   (load_val[i*WIDTH +: WIDTH]),
            .empty      (empty[i]),
            .expire     (expire[i]),
            .count      (count[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_n64_timer_bank.sv
// Self-checking bench for n64_timer_bank: directed scenarios plus random
// stimulus against a cycle-level behavioural model of the timer rules.
module tb_n64_timer_bank;
    import n64_timer_pkg::*;

    localparam int CH = 2;
    localparam int W  = 8;
`ifdef TIMER_PRESCALE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   start, stop, hold, reload_mode;
    logic [CH*W-1:0] load_val;
    logic [CH-1:0]   empty, expire;
    logic [CH*W-1:0] count;

    n64_timer_bank #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .PRESCALE(PRE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .reload_mode(reload_mode),
        .load_val   (load_val),
        .empty      (empty),
        .expire     (expire),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Model: remaining count, running flag, latched load/mode, pulse flag.
    int              m_cnt[CH];
    int              m_load[CH];
    bit              m_run[CH];
    bit              m_mode[CH];
    bit              m_exp[CH];
    int              m_pre;
    logic [CH-1:0]   e_empty, e_expire;
    logic [CH*W-1:0] e_count;
    int              checks;
    int              passes;

    task automatic model_edge();
        bit tick;
        int l;
        if (reset) begin
            m_pre = 0;
            for (int i = 0; i < CH; i++) begin
                m_cnt[i] = 0; m_load[i] = 0; m_run[i] = 0; m_mode[i] = 0; m_exp[i] = 0;
            end
        end else begin
            tick  = (m_pre == PRE - 1);
            m_pre = (m_pre + 1) % PRE;
            for (int i = 0; i < CH; i++) begin
                l        = int'(load_val[i*W +: W]);
                m_exp[i] = 0;
                if (start[i]) begin
                    m_load[i] = l;
                    m_mode[i] = reload_mode[i];
                    m_cnt[i]  = l;
                    m_run[i]  = (l != 0);
                    m_exp[i]  = (l == 0);
                end else if (stop[i]) begin
                    m_cnt[i] = 0;
                    m_run[i] = 0;
                end else if (!hold[i] && tick && m_run[i]) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin
                        m_exp[i] = 1;
                        if (m_mode[i]) m_cnt[i] = m_load[i];
                        else m_run[i] = 0;
                    end
                end
            end
        end
        for (int i = 0; i < CH; i++) begin
            e_empty[i]       = !m_run[i];
            e_expire[i]      = m_exp[i];
            e_count[i*W +: W] = W'(m_cnt[i]);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int ch, input int v);
        load_val[ch*W +: W] = W'(v);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = '0; stop = '0; hold = '0; reload_mode = '0; load_val = '0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (count !== '0) $display("[TB] FAIL reset count: got %h expected 0", count);
        else passes++;
        checks++;
        if (empty !== '1) $display("[TB] FAIL reset empty: got %b expected all ones", empty);
        else passes++;
        checks++;
        if (expire !== '0) $display("[TB] FAIL reset expire: got %b expected 0", expire);
        else passes++;
        step();
        checks++;
        if ({empty, expire, count} !== {e_empty, e_expire, e_count})
            $display("[TB] FAIL idle state: got %b/%b/%h expected %b/%b/%h",
                     empty, expire, count, e_empty, e_expire, e_count);
        else passes++;
    endtask

    task automatic test_oneshot();
        int low = 0, pulses = 0, other = 0;
        set_load(0, 35);
        reload_mode[0] = MODE_ONESHOT;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int n = 0; n < 40 * PRE; n++) begin
            checks++;
            if ({empty, expire, count} !== {e_empty, e_expire, e_count})
                $display("[TB] FAIL oneshot state: got %b/%b/%h expected %b/%b/%h",
                         empty, expire, count, e_empty, e_expire, e_count);
            else passes++;
            if (!empty[0]) low++;
            if (expire[0]) pulses++;
            if (!empty[1]) other++;
            step();
        end
`ifndef TIMER_PRESCALE_EN
        checks++;
        if (low != 35) $display("[TB] FAIL oneshot empty-low cycles: got %0d expected 35", low);
        else passes++;
`endif
        checks++;
        if (pulses != 1) $display("[TB] FAIL oneshot expire pulses: got %0d expected 1", pulses);
        else passes++;
        checks++;
        if (other != 0) $display("[TB] FAIL oneshot ch1 busy cycles: got %0d expected 0", other);
        else passes++;
    endtask

    task automatic test_autoreload();
        int pulses = 0, idle = 0;
        set_load(1, 4);
        reload_mode[1] = MODE_RELOAD;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        reload_mode[1] = MODE_ONESHOT;
        for (int n = 0; n < 20 * PRE; n++) begin
            step();
            checks++;
            if ({empty, expire, count} !== {e_empty, e_expire, e_count})
                $display("[TB] FAIL reload state: got %b/%b/%h expected %b/%b/%h",
                         empty, expire, count, e_empty, e_expire, e_count);
            else passes++;
            if (expire[1]) pulses++;
            if (empty[1]) idle++;
        end
`ifndef TIMER_PRESCALE_EN
        checks++;
        if (pulses != 5) $display("[TB] FAIL reload pulses: got %0d expected 5", pulses);
        else passes++;
`endif
        checks++;
        if (idle != 0) $display("[TB] FAIL reload empty cycles: got %0d expected 0", idle);
        else passes++;
        stop[1] = 1'b1;
        step();
        stop[1] = 1'b0;
        checks++;
        if (empty[1] !== 1'b1) $display("[TB] FAIL reload stop empty: got %b expected 1", empty[1]);
        else passes++;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            if (expire[1]) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) $display("[TB] FAIL reload pulses after stop: got %0d expected 0", pulses);
        else passes++;
    endtask

    task automatic test_hold();
        int low = 0;
        bit held = 0;
        set_load(0, 10);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int n = 0; n < 40 * PRE; n++) begin
            if (!empty[0]) low++;
            if (!held && count[W-1:0] == 8'd6) begin
                hold[0] = 1'b1;
                for (int h = 0; h < 5; h++) begin
                    step();
                    if (!empty[0]) low++;
                end
                hold[0] = 1'b0;
                held = 1;
                checks++;
                if (count[W-1:0] !== 8'd6) $display("[TB] FAIL hold frozen count: got %0d expected 6", count[W-1:0]);
                else passes++;
            end
            step();
            checks++;
            if ({empty, expire, count} !== {e_empty, e_expire, e_count})
                $display("[TB] FAIL hold state: got %b/%b/%h expected %b/%b/%h",
                         empty, expire, count, e_empty, e_expire, e_count);
            else passes++;
        end
`ifndef TIMER_PRESCALE_EN
        checks++;
        if (low != 15) $display("[TB] FAIL hold empty-low cycles: got %0d expected 15", low);
        else passes++;
`endif
    endtask

    task automatic test_restart();
        int n = 0;
        set_load(0, 10);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        while (count[W-1:0] != 8'd3 && n < 100) begin
            step();
            n++;
        end
        set_load(0, 8);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        checks++;
        if (count[W-1:0] !== 8'd8 || expire[0] !== 1'b0)
            $display("[TB] FAIL restart: got count=%0d expire=%b expected count=8 expire=0",
                     count[W-1:0], expire[0]);
        else passes++;
        set_load(1, 20);
        start[1] = 1'b1;
        stop[1]  = 1'b1;
        step();
        start[1] = 1'b0;
        stop[1]  = 1'b0;
        checks++;
        if (empty[1] !== 1'b0 || count[W +: W] !== 8'd20)
            $display("[TB] FAIL start-over-stop: got empty=%b count=%0d expected empty=0 count=20",
                     empty[1], count[W +: W]);
        else passes++;
        checks++;
        if ({empty, expire, count} !== {e_empty, e_expire, e_count})
            $display("[TB] FAIL restart state: got %b/%b/%h expected %b/%b/%h",
                     empty, expire, count, e_empty, e_expire, e_count);
        else passes++;
        stop = '1;
        step();
        stop = '0;
    endtask

    task automatic test_edges();
        int low = 0;
        set_load(0, 0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        checks++;
        if (expire[0] !== 1'b1 || empty[0] !== 1'b1)
            $display("[TB] FAIL zero load: got expire=%b empty=%b expected 1/1", expire[0], empty[0]);
        else passes++;
        step();
        checks++;
        if (expire[0] !== 1'b0) $display("[TB] FAIL zero load second cycle: got expire=%b expected 0", expire[0]);
        else passes++;
        set_load(0, 255);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int n = 0; n < 270 * PRE; n++) begin
            if (!empty[0]) low++;
            checks++;
            if ({empty, expire, count} !== {e_empty, e_expire, e_count})
                $display("[TB] FAIL max load state: got %b/%b/%h expected %b/%b/%h",
                         empty, expire, count, e_empty, e_expire, e_count);
            else passes++;
            step();
        end
`ifndef TIMER_PRESCALE_EN
        checks++;
        if (low != 255) $display("[TB] FAIL max load empty-low cycles: got %0d expected 255", low);
        else passes++;
`endif
        set_load(0, 50);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (empty !== '1 || count !== '0 || expire !== '0)
            $display("[TB] FAIL mid-count reset: got %b/%b/%h expected 11/00/0000", empty, expire, count);
        else passes++;
        step();
        checks++;
        if (expire !== '0) $display("[TB] FAIL after reset expire: got %b expected 00", expire);
        else passes++;
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < CH; i++) begin
                start[i]       = ($urandom_range(0, 9) == 0);
                stop[i]        = ($urandom_range(0, 19) == 0);
                hold[i]        = ($urandom_range(0, 4) == 0);
                reload_mode[i] = 1'($urandom_range(0, 1));
                r = int'($urandom_range(0, 19));
                if (r == 0) set_load(i, int'(CELL_1US));
                else if (r == 1) set_load(i, int'(CELL_3US));
                else set_load(i, int'($urandom_range(0, 6)));
            end
            step();
            checks++;
            if ({empty, expire, count} !== {e_empty, e_expire, e_count})
                $display("[TB] FAIL random state cycle %0d: got %b/%b/%h expected %b/%b/%h",
                         n, empty, expire, count, e_empty, e_expire, e_count);
            else passes++;
        end
        start = '0; hold = '0; reload_mode = '0;
        stop  = '1;
        step();
        stop  = '0;
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        int n = 0;
        set_load(0, 3);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        while (!expire[0] && n < 40) begin
            step();
            n++;
            checks++;
            if ({empty, expire, count} !== {e_empty, e_expire, e_count})
                $display("[TB] FAIL prescale state: got %b/%b/%h expected %b/%b/%h",
                         empty, expire, count, e_empty, e_expire, e_count);
            else passes++;
        end
        checks++;
        if (n < 9 || n > 12) $display("[TB] FAIL prescale latency: got %0d expected 9..12", n);
        else passes++;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        m_pre  = 0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_hold();
        test_restart();
        test_edges();
        test_random();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/n64_timer_bank.md
Name: n64_timer_bank

Overview:
- Bank of independent, parametrised down-counting interval timers for the N64 controller interface.
- Generates the bit-cell timing for the 1-wire controller protocol: bit periods, sample points and response timeouts.
- Each channel is a reloadable one-shot or auto-reload timer with a per-channel load value, hold (pause) and cancel.
- Each channel reports a level "empty" and a one-cycle "expire" pulse.

Parameters:
- CHANNELS, 2, number of independent timer channels (1..8).
- WIDTH, 8, counter width in bits; per-channel load values are WIDTH bits.
- PRESCALE, 1, clock divider applied to all channels; only used when TIMER_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  CHANNELS  per-channel start/restart strobe; loads load_val.
- stop  in  CHANNELS  per-channel cancel strobe.
- hold  in  CHANNELS  per-channel pause; counter freezes while high.
- reload_mode  in  CHANNELS  mode per channel: 1 = auto-reload, 0 = one-shot; sampled at start.
- load_val  in  CHANNELS*WIDTH  packed load values; channel i uses bits [i*WIDTH +: WIDTH].
- empty  out  CHANNELS  1 = channel idle/expired; 0 = counting.
- expire  out  CHANNELS  one-cycle pulse when a count completes.
- count  out  CHANNELS*WIDTH  packed current counter values.

Behaviour:
- Reset, per channel: count=0, empty=1, expire=0, latched load=0, latched mode=0. Reset applied mid-count aborts the count with no expire pulse.
- Per-channel states: IDLE (empty=1) and RUN (empty=0). Each channel latches load_val and reload_mode at start.
- Start, sampled at edge k, from any state: count<=L, empty<=0, latched load/mode updated. A start while in RUN restarts the count.
- Start with L=0: channel stays IDLE, and expire pulses at edge k (visible during cycle k+1).
- RUN, tick=1, hold=0:
  - count>1: count decrements by 1.
  - count==1 in one-shot mode: count<=0, empty<=1, expire<=1.
  - count==1 in auto-reload mode: count<=latched L, empty stays 0, expire<=1.
- Timing: for L>=1 with no hold, empty is low for exactly L cycles (edges k+1..k+L) and expire is high for the single cycle after edge k+L. Auto-reload period is exactly L cycles.
- Hold=1: count, empty and the channel state freeze, and no expire is generated. Start and stop still act while hold is high.
- Stop: count<=0, empty<=1, expire<=0. Stop does not generate an expire pulse.
- Priority, highest first: reset > start > stop > hold > decrement. Start and stop in the same cycle: start wins.
- In IDLE with no start, count stays 0 and expire stays 0.
- expire is a registered one-cycle pulse. It re-asserts on consecutive periods only when L=1 in auto-reload mode; in that case expire stays high continuously.
- Channels are fully independent; simultaneous events on different channels do not interact.
- No arithmetic wrap: the counter never decrements below 0, and load values are unsigned.

Optional Feature:
- TIMER_PRESCALE_EN defined:
  - Adds a shared free-running prescaler, 0..PRESCALE-1, that asserts tick once every PRESCALE clocks.
  - The prescaler resets to 0 on reset and is not reset by start.
  - Decrements in RUN occur only on tick, so the expiry latency is between (L-1)*PRESCALE+1 and L*PRESCALE clocks.
- TIMER_PRESCALE_EN undefined: tick is tied to 1, the PRESCALE parameter is ignored, and timing is exactly as specified above.

Decomposition:
- Package n64_timer_pkg:
  - Channel state encoding (IDLE, RUN).
  - Mode constants MODE_ONESHOT=0 and MODE_RELOAD=1.
  - Named N64 bit-timing load constants, e.g. 1 us and 3 us cell counts at the board clock.
- Sub-module n64_timer_channel holds one channel's counter, latches and FSM, with a tick input.
- The top level contains the prescaler (when enabled) and a generate loop over CHANNELS.

Test Plan:
- Reset, then start ch0 with load_val=35 one-shot -> empty[0] low 35 cycles; expire[0] pulses once at cycle 36; count steps 35..0; ch1 unaffected.
- Auto-reload ch1 with L=4, run 20 cycles -> expire[1] every 4 cycles (5 pulses); empty[1] stays 0; stop -> empty=1, no further pulses.
- Start ch0 with L=10, hold high for 5 cycles at count=6 -> count stays 6; expiry delayed by 5 cycles (empty low 15 cycles total).
- Restart ch0 at count=3 with L=8, and separately assert start+stop together -> count reloads to 8, no expire pulse; start wins over stop.
- Edge values: L=0 -> immediate single expire, empty stays 1; L=255 (WIDTH=8) -> empty low 255 cycles; reset asserted mid-count -> empty=1, count=0, no expire.
- With TIMER_PRESCALE_EN and PRESCALE=4, L=3 -> expire between 9 and 12 cycles after start; count decrements only on tick.
